bit_deserializer: RTL and testbench

//   Collects a serial bit stream, one bit per accepted beat, into WIDTH-bit words.
//   It sits upstream of the bitcell/word storage and feeds it complete words.
//   A one-word output holding register with valid/ready lets assembly of the next

---
 rtl/bit_deserializer.sv | 69 ++++++
 tb/tb_bit_deserializer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_deserializer.sv
// rtl/bit_deserializer.sv - serial bit stream to WIDTH-bit word assembler with one-word holding register
module bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_word,
    input  logic             out_ready,
    output logic [CW-1:0]    bit_count
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] assembled;
    logic [CW-1:0]    pos;
    logic             last_bit;
    logic             accept;
    logic             handoff;

    // Only the final bit of a word can be blocked, and only while the holding register stays occupied.
    assign last_bit = (bit_count == LAST);
    assign in_ready = !flush && !(last_bit && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;
    assign pos      = MSB_FIRST ? (LAST - bit_count) : bit_count;

    // Partial word with the incoming bit dropped into its slot.
    always_comb begin
        assembled      = shift_reg;
        assembled[pos] = in_bit;
    end

    // Word assembly and holding register; a final-bit accept reloads the holding register even during a handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_count <= '0;
            shift_reg <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
        end else begin
            if (handoff) begin
                out_valid <= 1'b0;
            end
            if (flush) begin
                bit_count <= '0;
                shift_reg <= '0;
            end else if (accept) begin
                if (last_bit) begin
                    out_word  <= assembled;
                    out_valid <= 1'b1;
                    bit_count <= '0;
                    shift_reg <= '0;
                end else begin
                    shift_reg <= assembled;
                    bit_count <= bit_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// tb/tb_bit_deserializer.sv - self-checking bench for bit_deserializer
module tb_bit_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_bit;
    logic       out_ready;
    logic       in_ready, in_ready_m;
    logic       out_valid, out_valid_m;
    logic [7:0] out_word, out_word_m;
    logic [2:0] bit_count, bit_count_m;

    int errors = 0;
    int checks = 0;
    int stalls = 0;

    logic [15:0] sb[$];

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .out_valid(out_valid), .out_word(out_word),
        .out_ready(out_ready), .bit_count(bit_count)
    );

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready_m), .out_valid(out_valid_m), .out_word(out_word_m),
        .out_ready(out_ready), .bit_count(bit_count_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Drive one bit; return after it is presented with in_ready high (accepted at the next edge).
    task automatic send_bit(input logic b);
        int budget;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_bit   = b;
        #1;
        budget = 20;
        while (!in_ready && budget > 0) begin
            stalls++;
            @(posedge clk);
            #2;
            budget--;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready stuck at %0b", in_ready);
        end
    endtask

    task automatic send_bits(input logic [7:0] w, input int from, input int to);
        for (int i = from; i < to; i++) send_bit(w[i]);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: every handoff seen mid-cycle is compared against the oldest expected word pair.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL sb_unexpected: got %0h expected none", out_word);
            end else begin
                e = sb.pop_front();
                check("word_lsb", {24'd0, out_word}, {24'd0, e[15:8]});
                check("word_msb", {24'd0, out_word_m}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        vecs[0] = '{8'h4D, 8'h4D, 8'hB2};
        vecs[1] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[2] = '{8'h01, 8'h01, 8'h80};
        vecs[3] = '{8'hF0, 8'hF0, 8'h0F};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[5] = '{8'h00, 8'h00, 8'h00};
        vecs[6] = '{8'h12, 8'h12, 8'h48};
        vecs[7] = '{8'h3C, 8'h3C, 8'h3C};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_word", {24'd0, out_word}, 32'd0);
        check("reset_bit_count", {29'd0, bit_count}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Test 1/2: single word, out_valid for exactly one cycle after the 8th accept.
        sb.push_back({8'h4D, 8'hB2});
        send_bits(8'h4D, 0, 8);
        idle();
        check("t1_valid_rise", {31'd0, out_valid}, 32'd1);
        check("t1_word_lsb", {24'd0, out_word}, 32'h4D);
        check("t2_word_msb", {24'd0, out_word_m}, 32'hB2);
        @(posedge clk); #1;
        check("t1_valid_fall", {31'd0, out_valid}, 32'd0);

        // Table-driven back-to-back words.
        for (int v = 0; v < 8; v++) begin
            sb.push_back({vecs[v].exp_lsb, vecs[v].exp_msb});
            send_bits(vecs[v].word, 0, 8);
        end
        idle();
        repeat (2) @(posedge clk);
        check("tbl_drained", sb.size(), 32'd0);

        // Test 3: backpressure on the final bit of the second word.
        out_ready = 1'b0;
        sb.push_back({8'h4D, 8'hB2});
        sb.push_back({8'hA5, 8'hA5});
        send_bits(8'h4D, 0, 8);
        send_bits(8'hA5, 0, 7);
        @(posedge clk); #1;
        in_valid = 1'b1; in_bit = 1'b1;
        #1;
        check("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("t3_bit_count", {29'd0, bit_count}, 32'd7);
        repeat (2) @(posedge clk);
        #2;
        check("t3_still_low", {31'd0, in_ready}, 32'd0);
        check("t3_word_held", {24'd0, out_word}, 32'h4D);
        out_ready = 1'b1;
        #1;
        check("t3_in_ready_up", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t3_valid_stays", {31'd0, out_valid}, 32'd1);
        check("t3_new_word", {24'd0, out_word}, 32'hA5);
        check("t3_count_wrap", {29'd0, bit_count}, 32'd0);
        @(posedge clk); #1;
        check("t3_valid_fall", {31'd0, out_valid}, 32'd0);

        // Test 4: flush mid-word while a word is held.
        out_ready = 1'b0;
        sb.push_back({8'h3C, 8'h3C});
        send_bits(8'h3C, 0, 8);
        send_bits(8'hFF, 0, 5);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        #1;
        check("t4_flush_ready", {31'd0, in_ready}, 32'd0);
        check("t4_count_before", {29'd0, bit_count}, 32'd5);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("t4_count_cleared", {29'd0, bit_count}, 32'd0);
        check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
        sb.push_back({8'h12, 8'h48});
        send_bits(8'h12, 0, 7);
        #1;
        check("t4_hold_word", {24'd0, out_word}, 32'h3C);
        out_ready = 1'b1;
        send_bits(8'h12, 7, 8);
        idle();
        repeat (2) @(posedge clk);
        check("t4_drained", sb.size(), 32'd0);

        // Test 5: asynchronous reset between edges with a held word and a partial word.
        out_ready = 1'b0;
        sb.push_back({8'hF0, 8'h0F});
        send_bits(8'hF0, 0, 8);
        send_bits(8'h07, 0, 3);
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_count", {29'd0, bit_count}, 32'd0);
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_word", {24'd0, out_word}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        sb.push_back({8'h5A, 8'h5A});
        send_bits(8'h5A, 0, 8);
        idle();
        repeat (2) @(posedge clk);
        check("t5_drained", sb.size(), 32'd0);

        // Test 6: 100 random words, out_ready held high, no stall expected.
        stalls = 0;
        for (int n = 0; n < 100; n++) begin
            logic [7:0] w;
            w = 8'($urandom);
            sb.push_back({w, rev8(w)});
            send_bits(w, 0, 8);
        end
        idle();
        repeat (2) @(posedge clk);
        check("t6_no_stall", stalls, 32'd0);
        check("t6_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
